// File: rtl/draw_sequencer.sv
// draw_sequencer
//
// Orchestrates one screen redraw: a full-screen background draw followed, in
// play-class states, by four 16x16 sprite draws (one per mole hole). Redraws
// are triggered by a change of game state or a mole-mask update; requests that
// arrive mid-frame collapse into a single pending redraw.
//
// Ports
//   iClock      in   1  system clock, rising edge
//   iResetn     in   1  asynchronous active-low reset
//   iState      in   3  game state (0 start, 2 game over, anything else play)
//   iMoleMask   in   4  bit n set = mole up in hole n
//   iMoleValid  in   1  pulse, iMoleMask has new content
//   oBgStart    out  1  pulse, start background draw
//   oBgSel      out  2  background image (0 start, 1 play field, 2 game over)
//   iBgDone     in   1  background drawer finished
//   oSprStart   out  1  pulse, start sprite draw
//   oSprX       out  8  sprite column
//   oSprY       out  7  sprite row
//   oSprSel     out  1  1 mole sprite, 0 empty hole
//   iSprDone    in   1  sprite drawer finished
//   oBusy       out  1  sequencer is not idle
//   oFrameDone  out  1  pulse, redraw sequence complete
//   oError      out  1  sticky, a drawer failed to finish in time

module draw_sequencer #(
    parameter int unsigned TIMEOUT = 32768,
    parameter logic [6:0]  HOLE_Y  = 7'd72,
    parameter logic [7:0]  HOLE_X0 = 8'd24,
    parameter logic [7:0]  HOLE_X1 = 8'd64,
    parameter logic [7:0]  HOLE_X2 = 8'd104,
    parameter logic [7:0]  HOLE_X3 = 8'd144
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic [2:0] iState,
    input  logic [3:0] iMoleMask,
    input  logic       iMoleValid,
    output logic       oBgStart,
    output logic [1:0] oBgSel,
    input  logic       iBgDone,
    output logic       oSprStart,
    output logic [7:0] oSprX,
    output logic [6:0] oSprY,
    output logic       oSprSel,
    input  logic       iSprDone,
    output logic       oBusy,
    output logic       oFrameDone,
    output logic       oError
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StBgStart,
        StBgWait,
        StSprStart,
        StSprWait,
        StSprNext,
        StFinish
    } state_e;

    state_e          state;
    logic [2:0]      lat_state;
    logic [3:0]      lat_mask;
    logic            pending;
    logic [1:0]      hole;
    logic [1:0]      next_hole;
    logic [CntW-1:0] wait_cnt;
    logic            request;

    // A state change and a mask pulse in the same cycle form one request.
    assign request   = (iState != lat_state) || iMoleValid;
    assign next_hole = hole + 2'd1;

    function automatic logic [1:0] bg_sel_of(input logic [2:0] s);
        logic [1:0] sel;
        case (s)
            3'd0:    sel = 2'd0;
            3'd2:    sel = 2'd2;
            default: sel = 2'd1;
        endcase
        return sel;
    endfunction

    function automatic logic is_play(input logic [2:0] s);
        return (s != 3'd0) && (s != 3'd2);
    endfunction

    function automatic logic [7:0] hole_x(input logic [1:0] n);
        logic [7:0] x;
        case (n)
            2'd0:    x = HOLE_X0;
            2'd1:    x = HOLE_X1;
            2'd2:    x = HOLE_X2;
            default: x = HOLE_X3;
        endcase
        return x;
    endfunction

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state      <= StIdle;
            lat_state  <= 3'd0;
            lat_mask   <= 4'd0;
            pending    <= 1'b0;
            hole       <= 2'd0;
            wait_cnt   <= '0;
            oBgStart   <= 1'b0;
            oBgSel     <= 2'd0;
            oSprStart  <= 1'b0;
            oSprX      <= 8'd0;
            oSprY      <= 7'd0;
            oSprSel    <= 1'b0;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b0;
            oError     <= 1'b0;
        end else begin
            // Pulse outputs are high only in the cycle after they are set.
            oBgStart   <= 1'b0;
            oSprStart  <= 1'b0;
            oFrameDone <= 1'b0;

            // Mid-frame requests collapse into one flag; the branches below
            // that latch a new frame override this.
            if (request && (state != StIdle)) begin
                pending <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (request) begin
                        lat_state <= iState;
                        lat_mask  <= iMoleMask;
                        pending   <= 1'b0;
                        oBgStart  <= 1'b1;
                        oBgSel    <= bg_sel_of(iState);
                        oBusy     <= 1'b1;
                        state     <= StBgStart;
                    end
                end

                // Done is not sampled here, so a done coincident with the
                // start pulse is ignored.
                StBgStart: begin
                    wait_cnt <= '0;
                    state    <= StBgWait;
                end

                StBgWait: begin
                    if (iBgDone) begin
                        if (is_play(lat_state)) begin
                            hole      <= 2'd0;
                            oSprStart <= 1'b1;
                            oSprX     <= hole_x(2'd0);
                            oSprY     <= HOLE_Y;
                            oSprSel   <= lat_mask[0];
                            state     <= StSprStart;
                        end else begin
                            oFrameDone <= 1'b1;
                            state      <= StFinish;
                        end
                    end else if (wait_cnt == CntMax) begin
                        oError     <= 1'b1;
                        oFrameDone <= 1'b1;
                        state      <= StFinish;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                StSprStart: begin
                    wait_cnt <= '0;
                    state    <= StSprWait;
                end

                StSprWait: begin
                    if (iSprDone) begin
                        state <= StSprNext;
                    end else if (wait_cnt == CntMax) begin
                        oError     <= 1'b1;
                        oFrameDone <= 1'b1;
                        state      <= StFinish;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                StSprNext: begin
                    if (hole == 2'd3) begin
                        oFrameDone <= 1'b1;
                        state      <= StFinish;
                    end else begin
                        hole      <= next_hole;
                        oSprStart <= 1'b1;
                        oSprX     <= hole_x(next_hole);
                        oSprY     <= HOLE_Y;
                        oSprSel   <= lat_mask[next_hole];
                        state     <= StSprStart;
                    end
                end

                // A request in this very cycle is folded in with pending so
                // a one-cycle iMoleValid here is not lost.
                StFinish: begin
                    if (pending || request) begin
                        lat_state <= iState;
                        lat_mask  <= iMoleMask;
                        pending   <= 1'b0;
                        oBgStart  <= 1'b1;
                        oBgSel    <= bg_sel_of(iState);
                        state     <= StBgStart;
                    end else begin
                        oBusy <= 1'b0;
                        state <= StIdle;
                    end
                end

                default: begin
                    oBusy <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer. Drawer handshakes are driven by hand
// from directed scenarios; expected values are hand-computed constants.

module tb_draw_sequencer;

    logic       iClock = 1'b0;
    logic       iResetn = 1'b0;
    logic [2:0] iState = 3'd0;
    logic [3:0] iMoleMask = 4'd0;
    logic       iMoleValid = 1'b0;
    logic       iBgDone = 1'b0;
    logic       iSprDone = 1'b0;
    logic       oBgStart;
    logic [1:0] oBgSel;
    logic       oSprStart;
    logic [7:0] oSprX;
    logic [6:0] oSprY;
    logic       oSprSel;
    logic       oBusy;
    logic       oFrameDone;
    logic       oError;

    int checks = 0;
    int passes = 0;

    draw_sequencer #(
        .TIMEOUT(16)
    ) dut (
        .iClock     (iClock),
        .iResetn    (iResetn),
        .iState     (iState),
        .iMoleMask  (iMoleMask),
        .iMoleValid (iMoleValid),
        .oBgStart   (oBgStart),
        .oBgSel     (oBgSel),
        .iBgDone    (iBgDone),
        .oSprStart  (oSprStart),
        .oSprX      (oSprX),
        .oSprY      (oSprY),
        .oSprSel    (oSprSel),
        .iSprDone   (iSprDone),
        .oBusy      (oBusy),
        .oFrameDone (oFrameDone),
        .oError     (oError)
    );

    initial forever #5 iClock = ~iClock;

    function automatic logic [7:0] exp_x(input int i);
        case (i)
            0:       return 8'd24;
            1:       return 8'd64;
            2:       return 8'd104;
            default: return 8'd144;
        endcase
    endfunction

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic wait_spr_start(output bit ok);
        int n = 0;
        while (!oSprStart && n < 40) begin
            step();
            n++;
        end
        ok = oSprStart;
    endtask

    task automatic wait_frame_done(output bit ok);
        int n = 0;
        while (!oFrameDone && n < 40) begin
            step();
            n++;
        end
        ok = oFrameDone;
    endtask

    task automatic serve_bg();
        iBgDone = 1'b1;
        step();
        iBgDone = 1'b0;
    endtask

    // Serves holes first..last, checking each sprite request and its hold.
    task automatic serve_sprites(input logic [3:0] mask, input int first, input int last,
                                 input string tag);
        bit ok;
        for (int i = first; i <= last; i++) begin
            wait_spr_start(ok);
            checks++;
            if (!ok) $display("FAIL %s_spr%0d_start: no oSprStart within 40 cycles", tag, i);
            else passes++;
            checks++;
            if (oSprX !== exp_x(i) || oSprY !== 7'd72 || oSprSel !== mask[i])
                $display("FAIL %s_spr%0d_coord: got x=%0d y=%0d sel=%b, want x=%0d y=72 sel=%b",
                         tag, i, oSprX, oSprY, oSprSel, exp_x(i), mask[i]);
            else passes++;
            step();
            checks++;
            if (oSprStart !== 1'b0 || oSprX !== exp_x(i) || oSprSel !== mask[i])
                $display("FAIL %s_spr%0d_hold: got start=%b x=%0d sel=%b, want 0 %0d %b",
                         tag, i, oSprStart, oSprX, oSprSel, exp_x(i), mask[i]);
            else passes++;
            iSprDone = 1'b1;
            step();
            iSprDone = 1'b0;
        end
    endtask

    task automatic test_reset();
        int starts = 0;
        int busy = 0;
        #2;
        checks++;
        if ({oBgStart, oBgSel, oSprStart, oSprX, oSprY, oSprSel} !== 20'd0)
            $display("FAIL reset_draw_outs: got %h want 0",
                     {oBgStart, oBgSel, oSprStart, oSprX, oSprY, oSprSel});
        else passes++;
        checks++;
        if ({oBusy, oFrameDone, oError} !== 3'b000)
            $display("FAIL reset_status: got %b want 000", {oBusy, oFrameDone, oError});
        else passes++;
        @(negedge iClock);
        iResetn = 1'b1;
        repeat (5) begin
            step();
            starts += int'(oBgStart);
            busy   += int'(oBusy);
        end
        checks++;
        if (starts != 0 || busy != 0)
            $display("FAIL reset_idle_state0: got starts=%0d busy=%0d want 0 0", starts, busy);
        else passes++;
    endtask

    task automatic test_play_entry();
        bit ok;
        iState = 3'd1;
        step();
        checks++;
        if (oBgStart !== 1'b1 || oBgSel !== 2'd1 || oBusy !== 1'b1)
            $display("FAIL entry_bg_start: got start=%b sel=%0d busy=%b want 1 1 1",
                     oBgStart, oBgSel, oBusy);
        else passes++;
        step();
        checks++;
        if (oBgStart !== 1'b0)
            $display("FAIL entry_bg_pulse: got %b want 0", oBgStart);
        else passes++;
        serve_bg();
        serve_sprites(4'b0000, 0, 3, "entry");
        wait_frame_done(ok);
        checks++;
        if (!ok) $display("FAIL entry_frame_done: got 0 want 1");
        else passes++;
        step();
        checks++;
        if (oFrameDone !== 1'b0 || oBusy !== 1'b0)
            $display("FAIL entry_idle: got done=%b busy=%b want 0 0", oFrameDone, oBusy);
        else passes++;
    endtask

    task automatic test_mask();
        bit ok;
        int extra = 0;
        iMoleMask  = 4'b0101;
        iMoleValid = 1'b1;
        step();
        iMoleValid = 1'b0;
        checks++;
        if (oBgStart !== 1'b1 || oBgSel !== 2'd1)
            $display("FAIL mask_bg_start: got start=%b sel=%0d want 1 1", oBgStart, oBgSel);
        else passes++;
        // Mask changes without a valid pulse must not reach this frame.
        iMoleMask = 4'b1010;
        step();
        serve_bg();
        serve_sprites(4'b0101, 0, 3, "mask");
        wait_frame_done(ok);
        checks++;
        if (!ok) $display("FAIL mask_frame_done: got 0 want 1");
        else passes++;
        repeat (6) begin
            step();
            extra += int'(oFrameDone) + int'(oBgStart);
        end
        checks++;
        if (extra != 0 || oBusy !== 1'b0)
            $display("FAIL mask_single_frame: got extra=%0d busy=%b want 0 0", extra, oBusy);
        else passes++;
    endtask

    task automatic test_gameover();
        int starts = 0;
        iState     = 3'd2;
        iMoleValid = 1'b1;
        step();
        iMoleValid = 1'b0;
        checks++;
        if (oBgStart !== 1'b1 || oBgSel !== 2'd2)
            $display("FAIL over_bg_start: got start=%b sel=%0d want 1 2", oBgStart, oBgSel);
        else passes++;
        iBgDone = 1'b1;
        step();
        iBgDone = 1'b0;
        step();
        checks++;
        if (oFrameDone !== 1'b0 || oBusy !== 1'b1)
            $display("FAIL over_early_done: got done=%b busy=%b want 0 1", oFrameDone, oBusy);
        else passes++;
        serve_bg();
        checks++;
        if (oFrameDone !== 1'b1 || oSprStart !== 1'b0)
            $display("FAIL over_finish: got done=%b spr=%b want 1 0", oFrameDone, oSprStart);
        else passes++;
        step();
        checks++;
        if (oBusy !== 1'b0)
            $display("FAIL over_busy_low: got %b want 0", oBusy);
        else passes++;
        repeat (6) begin
            step();
            starts += int'(oBgStart);
        end
        checks++;
        if (starts != 0)
            $display("FAIL over_one_redraw: got %0d extra starts want 0", starts);
        else passes++;
    endtask

    task automatic test_pending();
        bit ok;
        int starts = 0;
        iState = 3'd1;
        step();
        checks++;
        if (oBgStart !== 1'b1 || oBgSel !== 2'd1)
            $display("FAIL pend_bg_start: got start=%b sel=%0d want 1 1", oBgStart, oBgSel);
        else passes++;
        step();
        serve_bg();
        wait_spr_start(ok);
        checks++;
        if (!ok || oSprX !== 8'd24 || oSprSel !== 1'b0)
            $display("FAIL pend_spr0: got ok=%b x=%0d sel=%b want 1 24 0", ok, oSprX, oSprSel);
        else passes++;
        step();
        iMoleMask  = 4'b0011;
        iMoleValid = 1'b1;
        step();
        iMoleValid = 1'b0;
        step();
        iMoleValid = 1'b1;
        step();
        iMoleValid = 1'b0;
        iSprDone   = 1'b1;
        step();
        iSprDone   = 1'b0;
        serve_sprites(4'b1010, 1, 3, "pend1");
        wait_frame_done(ok);
        checks++;
        if (!ok) $display("FAIL pend_frame1_done: got 0 want 1");
        else passes++;
        step();
        checks++;
        if (oBgStart !== 1'b1 || oBusy !== 1'b1 || oFrameDone !== 1'b0)
            $display("FAIL pend_restart: got start=%b busy=%b done=%b want 1 1 0",
                     oBgStart, oBusy, oFrameDone);
        else passes++;
        step();
        serve_bg();
        serve_sprites(4'b0011, 0, 3, "pend2");
        wait_frame_done(ok);
        checks++;
        if (!ok) $display("FAIL pend_frame2_done: got 0 want 1");
        else passes++;
        repeat (8) begin
            step();
            starts += int'(oBgStart);
        end
        checks++;
        if (starts != 0 || oBusy !== 1'b0)
            $display("FAIL pend_only_one: got starts=%0d busy=%b want 0 0", starts, oBusy);
        else passes++;
    endtask

    task automatic test_timeout();
        iMoleValid = 1'b1;
        step();
        iMoleValid = 1'b0;
        step();
        checks++;
        if (oError !== 1'b0)
            $display("FAIL tmo_err_initial: got %b want 0", oError);
        else passes++;
        repeat (15) step();
        checks++;
        if (oError !== 1'b0 || oFrameDone !== 1'b0)
            $display("FAIL tmo_early: got err=%b done=%b want 0 0", oError, oFrameDone);
        else passes++;
        step();
        checks++;
        if (oError !== 1'b1 || oFrameDone !== 1'b1)
            $display("FAIL tmo_fire: got err=%b done=%b want 1 1", oError, oFrameDone);
        else passes++;
        step();
        checks++;
        if (oBusy !== 1'b0 || oError !== 1'b1 || oFrameDone !== 1'b0)
            $display("FAIL tmo_after: got busy=%b err=%b done=%b want 0 1 0",
                     oBusy, oError, oFrameDone);
        else passes++;
        repeat (5) step();
        checks++;
        if (oError !== 1'b1)
            $display("FAIL tmo_sticky: got %b want 1", oError);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int activity = 0;
        iMoleValid = 1'b1;
        step();
        iMoleValid = 1'b0;
        step();
        serve_bg();
        serve_sprites(4'b0011, 0, 1, "rst");
        wait_spr_start(ok);
        checks++;
        if (!ok || oSprX !== 8'd104)
            $display("FAIL rst_spr2: got ok=%b x=%0d want 1 104", ok, oSprX);
        else passes++;
        step();
        #2;
        iResetn = 1'b0;
        #1;
        checks++;
        if ({oBgStart, oBgSel, oSprStart, oSprX, oSprY, oSprSel} !== 20'd0)
            $display("FAIL rst_mid_draw_outs: got %h want 0",
                     {oBgStart, oBgSel, oSprStart, oSprX, oSprY, oSprSel});
        else passes++;
        checks++;
        if ({oBusy, oFrameDone, oError} !== 3'b000)
            $display("FAIL rst_mid_status: got %b want 000", {oBusy, oFrameDone, oError});
        else passes++;
        iState = 3'd0;
        step();
        step();
        @(negedge iClock);
        iResetn = 1'b1;
        repeat (8) begin
            step();
            activity += int'(oBgStart) + int'(oFrameDone) + int'(oBusy) + int'(oSprStart);
        end
        checks++;
        if (activity != 0)
            $display("FAIL rst_mid_idle: got activity=%0d want 0", activity);
        else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_play_entry();
        test_mask();
        test_gameover();
        test_pending();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
